btn_responder: RTL and testbench

//  Bus responder for the push-button port of the miniRV SoC bridge (the read-side peer of the bridge's btn interface).

---
 rtl/btn_responder_pkg.sv | 18 +
 rtl/btn_debounce.sv | 55 +++++
 rtl/btn_responder.sv | 101 ++++++++++
 tb/tb_btn_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/btn_responder_pkg.sv
// Shared register offsets and flag-update helper for the push-button responder.
package btn_responder_pkg;

  localparam int unsigned BUS_W = 32;

  typedef enum logic [1:0] {
    BTN_OFF_STATE = 2'd0,
    BTN_OFF_PRESS = 2'd1,
    BTN_OFF_REL   = 2'd2,
    BTN_OFF_IRQEN = 2'd3
  } btn_off_e;

  // Sticky W1C flag bit: a set on the same edge as a clear wins.
  function automatic logic w1c_bit(input logic flag, input logic clr, input logic set);
    return (flag & ~clr) | set;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter, debounced level and
// single-cycle rise/fall strobes that coincide with the level update edge.
module btn_debounce #(
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned CNT_W      = 18
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r;
  logic             sync2_r;
  logic             level_r;
  logic [CNT_W-1:0] cnt_r;
  logic             accept_s;

  // New level is accepted on the edge where the mismatch has lasted DEB_CYCLES samples.
  always_comb begin
    accept_s = (sync2_r != level_r) && (cnt_r == CNT_LAST);
  end

  // Synchroniser, stability counter and debounced level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      level_r <= 1'b0;
      cnt_r   <= CNT_ZERO;
    end else begin
      sync1_r <= btn_i;
      sync2_r <= sync1_r;
      if (sync2_r == level_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == CNT_LAST) begin
        level_r <= sync2_r;
        cnt_r   <= CNT_ZERO;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign level_o = level_r;
  assign rise_o  = accept_s & sync2_r;
  assign fall_o  = accept_s & ~sync2_r;

endmodule

// File: rtl/btn_responder.sv
// Push-button bus responder: per-button debouncers plus the STATE/PRESS/RELEASE/IRQ_EN
// register file with combinational read-back and a level interrupt.
module btn_responder
  import btn_responder_pkg::*;
#(
  parameter int unsigned NUM_BTN    = 5,
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned CNT_W      = 18
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NUM_BTN-1:0] btn_i,
  input  logic [31:0]        addr_i,
  input  logic               we_i,
  input  logic [31:0]        data_i,
  output logic [31:0]        data_o,
  output logic               irq_o
);

  localparam logic [NUM_BTN-1:0] BTN_ZERO = {NUM_BTN{1'b0}};

  logic [NUM_BTN-1:0] state_s;
  logic [NUM_BTN-1:0] rise_s;
  logic [NUM_BTN-1:0] fall_s;
  logic [NUM_BTN-1:0] press_r;
  logic [NUM_BTN-1:0] release_r;
  logic [NUM_BTN-1:0] irq_en_r;
  logic [NUM_BTN-1:0] press_clr_s;
  logic [NUM_BTN-1:0] release_clr_s;
  logic [NUM_BTN-1:0] press_nxt_s;
  logic [NUM_BTN-1:0] release_nxt_s;
  logic [BUS_W-1:0]   rd_s;
  btn_off_e           off_s;
  logic               unused_s;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
    btn_debounce #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_deb (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .btn_i   (btn_i[gi]),
      .level_o (state_s[gi]),
      .rise_o  (rise_s[gi]),
      .fall_o  (fall_s[gi])
    );
  end

  assign off_s    = btn_off_e'(addr_i[3:2]);
  assign unused_s = ^{addr_i[31:4], addr_i[1:0], data_i};

  // W1C clear masks and next flag values; bits above NUM_BTN are simply not sliced in.
  always_comb begin
    press_clr_s   = BTN_ZERO;
    release_clr_s = BTN_ZERO;
    if (we_i && (off_s == BTN_OFF_PRESS)) begin
      press_clr_s = data_i[NUM_BTN-1:0];
    end else if (we_i && (off_s == BTN_OFF_REL)) begin
      release_clr_s = data_i[NUM_BTN-1:0];
    end else begin
      press_clr_s   = BTN_ZERO;
      release_clr_s = BTN_ZERO;
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      press_nxt_s[i]   = w1c_bit(press_r[i], press_clr_s[i], rise_s[i]);
      release_nxt_s[i] = w1c_bit(release_r[i], release_clr_s[i], fall_s[i]);
    end
  end

  // Flag and interrupt-enable registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      press_r   <= BTN_ZERO;
      release_r <= BTN_ZERO;
      irq_en_r  <= BTN_ZERO;
    end else begin
      press_r   <= press_nxt_s;
      release_r <= release_nxt_s;
      if (we_i && (off_s == BTN_OFF_IRQEN)) begin
        irq_en_r <= data_i[NUM_BTN-1:0];
      end
    end
  end

  // Read mux, zero-extended to the bus width.
  always_comb begin
    rd_s = 32'd0;
    case (off_s)
      BTN_OFF_STATE: rd_s[NUM_BTN-1:0] = state_s;
      BTN_OFF_PRESS: rd_s[NUM_BTN-1:0] = press_r;
      BTN_OFF_REL:   rd_s[NUM_BTN-1:0] = release_r;
      BTN_OFF_IRQEN: rd_s[NUM_BTN-1:0] = irq_en_r;
      default:       rd_s = 32'd0;
    endcase
  end

  assign data_o = rd_s;
  assign irq_o  = |(press_r & irq_en_r);

endmodule

// File: tb/tb_btn_responder.sv
// Directed bench for btn_responder (NUM_BTN=5, DEB_CYCLES=4, CNT_W=3): a vector table
// plus hand-written bounce, race and reset-during-debounce sequences.
module tb_btn_responder;

  localparam logic [1:0] OFF_ST  = 2'd0;
  localparam logic [1:0] OFF_PR  = 2'd1;
  localparam logic [1:0] OFF_REL = 2'd2;
  localparam logic [1:0] OFF_IE  = 2'd3;

  logic        clk_i;
  logic        rst_i;
  logic [4:0]  btn_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [31:0] data_i;
  logic [31:0] data_o;
  logic        irq_o;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic [4:0]  btn;
    logic [1:0]  off;
    logic        we;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        irq;
  } vec_t;

  vec_t vecs[$];

  btn_responder #(
    .NUM_BTN    (5),
    .DEB_CYCLES (4),
    .CNT_W      (3)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .btn_i  (btn_i),
    .addr_i (addr_i),
    .we_i   (we_i),
    .data_i (data_i),
    .data_o (data_o),
    .irq_o  (irq_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic add(input logic [4:0] b, input logic [1:0] off, input logic we,
                     input logic [31:0] wd, input logic [31:0] exp, input logic irq);
    vec_t v;
    v.btn = b; v.off = off; v.we = we; v.wd = wd; v.exp = exp; v.irq = irq;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [4:0] b, input logic [1:0] off, input logic we,
                       input logic [31:0] wd, input logic rst);
    btn_i  = b;
    addr_i = {28'd0, off, 2'b00};
    we_i   = we;
    data_i = wd;
    rst_i  = rst;
  endtask

  // Drive inputs in the low phase, let one rising edge pass, return at the next falling edge.
  task automatic step(input logic [4:0] b, input logic [1:0] off, input logic we,
                      input logic [31:0] wd, input logic rst);
    drive(b, off, we, wd, rst);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string name);
    addr_i = {28'd0, off, 2'b00};
    we_i   = 1'b0;
    #1;
    chk(name, data_o, exp);
  endtask

  task automatic chk_irq(input logic exp, input string name);
    chk(name, {31'd0, irq_o}, {31'd0, exp});
  endtask

  initial begin
    // Press btn0: STATE/PRESS appear after E0+5, not after E0+4.
    add(5'h01, OFF_ST, 1'b0, 32'd0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) add(5'h01, OFF_ST, 1'b0, 32'd0, 32'h0, 1'b0);
    add(5'h01, OFF_ST, 1'b0, 32'd0, 32'h1, 1'b0);
    add(5'h01, OFF_PR, 1'b0, 32'd0, 32'h1, 1'b0);
    // Press btn1 as well.
    for (int i = 0; i < 6; i++) add(5'h03, OFF_ST, 1'b0, 32'd0, 32'h1, 1'b0);
    add(5'h03, OFF_ST, 1'b0, 32'd0, 32'h3, 1'b0);
    // W1C on PRESS, zero write, write to read-only STATE.
    add(5'h03, OFF_PR, 1'b1, 32'h1, 32'h3, 1'b0);
    add(5'h03, OFF_PR, 1'b1, 32'h0, 32'h2, 1'b0);
    add(5'h03, OFF_PR, 1'b0, 32'd0, 32'h2, 1'b0);
    add(5'h03, OFF_ST, 1'b1, 32'h0, 32'h3, 1'b0);
    add(5'h03, OFF_ST, 1'b0, 32'd0, 32'h3, 1'b0);
    add(5'h03, OFF_REL, 1'b0, 32'd0, 32'h0, 1'b0);
    // IRQ_EN read/write, irq follows, upper data bits ignored.
    add(5'h03, OFF_IE, 1'b1, 32'h1F, 32'h0, 1'b0);
    add(5'h03, OFF_IE, 1'b0, 32'd0, 32'h1F, 1'b1);
    add(5'h03, OFF_IE, 1'b1, 32'h0, 32'h1F, 1'b1);
    add(5'h03, OFF_IE, 1'b1, 32'hFFFF_FFE0, 32'h0, 1'b0);
    add(5'h03, OFF_IE, 1'b0, 32'd0, 32'h0, 1'b0);
    // Release both buttons: RELEASE appears after H0+5.
    for (int i = 0; i < 6; i++) add(5'h00, OFF_REL, 1'b0, 32'd0, 32'h0, 1'b0);
    add(5'h00, OFF_REL, 1'b0, 32'd0, 32'h3, 1'b0);
    add(5'h00, OFF_ST, 1'b0, 32'd0, 32'h0, 1'b0);
    add(5'h00, OFF_REL, 1'b1, 32'h3, 32'h3, 1'b0);
    add(5'h00, OFF_REL, 1'b0, 32'd0, 32'h0, 1'b0);
    add(5'h00, OFF_PR, 1'b1, 32'h2, 32'h2, 1'b0);
    add(5'h00, OFF_PR, 1'b0, 32'd0, 32'h0, 1'b0);

    drive(5'h00, OFF_ST, 1'b0, 32'd0, 1'b1);
    @(negedge clk_i);

    // Reset held for two edges, then all offsets read 0.
    step(5'h00, OFF_ST, 1'b0, 32'd0, 1'b1);
    step(5'h00, OFF_ST, 1'b0, 32'd0, 1'b1);
    rst_i = 1'b0;
    rd(OFF_ST, 32'h0, "reset STATE");
    rd(OFF_PR, 32'h0, "reset PRESS");
    rd(OFF_REL, 32'h0, "reset RELEASE");
    rd(OFF_IE, 32'h0, "reset IRQ_EN");
    chk_irq(1'b0, "reset irq");
    @(negedge clk_i);

    foreach (vecs[i]) begin
      drive(vecs[i].btn, vecs[i].off, vecs[i].we, vecs[i].wd, 1'b0);
      #1;
      chk($sformatf("vec%0d data", i), data_o, vecs[i].exp);
      chk($sformatf("vec%0d irq", i), {31'd0, irq_o}, {31'd0, vecs[i].irq});
      @(posedge clk_i);
      @(negedge clk_i);
    end

    // Bounce on btn2: high 3, low 1, then a long run.
    for (int k = 0; k < 3; k++) step(5'h04, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_PR, 32'h0, "bounce press early");
    step(5'h00, OFF_ST, 1'b0, 32'd0, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      step(5'h04, OFF_ST, 1'b0, 32'd0, 1'b0);
      if (k < 6) begin
        rd(OFF_PR, 32'h0, $sformatf("bounce press k%0d", k));
        rd(OFF_ST, 32'h0, $sformatf("bounce state k%0d", k));
      end else begin
        rd(OFF_ST, 32'h4, "bounce state final");
        rd(OFF_PR, 32'h4, "bounce press final");
      end
    end

    // Race: W1C of PRESS[0] on the edge the btn0 press is accepted.
    for (int k = 0; k < 5; k++) step(5'h05, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_PR, 32'h4, "race before accept");
    step(5'h05, OFF_PR, 1'b1, 32'h1, 1'b0);
    rd(OFF_PR, 32'h5, "race set wins");
    step(5'h05, OFF_PR, 1'b1, 32'h1, 1'b0);
    rd(OFF_PR, 32'h4, "race plain clear");

    // IRQ on btn4, clear, release, re-press and reset mid-debounce.
    step(5'h05, OFF_IE, 1'b1, 32'h10, 1'b0);
    for (int k = 0; k < 5; k++) step(5'h15, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_PR, 32'h4, "irq press pending");
    chk_irq(1'b0, "irq before accept");
    step(5'h15, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_PR, 32'h14, "irq press accepted");
    chk_irq(1'b1, "irq asserted");
    step(5'h15, OFF_PR, 1'b1, 32'h10, 1'b0);
    rd(OFF_PR, 32'h4, "irq press cleared");
    chk_irq(1'b0, "irq deasserted");
    for (int k = 0; k < 6; k++) step(5'h05, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_REL, 32'h10, "btn4 release");
    for (int k = 0; k < 3; k++) step(5'h15, OFF_ST, 1'b0, 32'd0, 1'b0);
    step(5'h15, OFF_ST, 1'b0, 32'd0, 1'b1);
    rst_i = 1'b0;
    rd(OFF_ST, 32'h0, "midreset STATE");
    rd(OFF_PR, 32'h0, "midreset PRESS");
    rd(OFF_IE, 32'h0, "midreset IRQ_EN");
    chk_irq(1'b0, "midreset irq");
    for (int k = 0; k < 5; k++) step(5'h15, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_PR, 32'h0, "postreset press at 5");
    step(5'h15, OFF_ST, 1'b0, 32'd0, 1'b0);
    rd(OFF_PR, 32'h15, "postreset press at 6");
    rd(OFF_ST, 32'h15, "postreset state at 6");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
